// File: rtl/mvm_ctrl_relu.sv
// mvm_ctrl_relu
// Sequencing controller for the matrix-vector ReLU datapath.
// It loads an N-element vector into vector memory over a valid/ready input.
// It then computes G = M/P row groups of P lanes each. Every group runs one
// accumulator clear, N address-issue cycles and two pipeline-flush cycles.
// The P lane results of each group are then drained one per handshake.
//
// Optional feature: define MVM_CTRL_STALL_CNT_EN to add the 16-bit saturating
// output stall counter port stall_cnt.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   s_valid    input element valid (the element goes straight to the datapath)
//   s_ready    controller accepts an element (high only while loading)
//   wr_en_x    vector memory write enable
//   addr_x     vector memory address, used for both write and read
//   addr_w     weight ROM address, shared by all lanes (g*N + j)
//   clear_acc  clears all lane accumulators
//   en_acc     accumulate enable, issued address delayed by two cycles
//   f_sel      output lane select
//   m_valid    selected lane result valid
//   m_ready    downstream accepts result
//   m_last     final lane of final group
//   busy       high in every state except LOAD
//   stall_cnt  (MVM_CTRL_STALL_CNT_EN only) cycles with m_valid && !m_ready
module mvm_ctrl_relu #(
  parameter int M = 8,
  parameter int N = 8,
  parameter int P = 1,
  localparam int VW = $clog2(N),
  localparam int AW = $clog2(M * N / P),
  localparam int G  = M / P,
  localparam int GW = (G > 1) ? $clog2(G) : 1,
  localparam int KW = (P > 1) ? $clog2(P) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          wr_en_x,
  output logic [VW-1:0] addr_x,
  output logic [AW-1:0] addr_w,
  output logic          clear_acc,
  output logic          en_acc,
  output logic [P-1:0]  f_sel,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
`ifdef MVM_CTRL_STALL_CNT_EN
  output logic [15:0]   stall_cnt,
`endif
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [VW-1:0] ld_r, ld_s;
  logic [VW-1:0] j_r, j_s;
  logic [GW-1:0] g_r, g_s;
  logic [KW-1:0] k_r, k_s;
  logic [1:0]    pipe_r;
  logic          issue_s;
  logic          k_last_s;
  logic          g_last_s;

  assign k_last_s = (k_r == KW'(P - 1));
  assign g_last_s = (g_r == GW'(G - 1));

  // State, counter and en_acc delay-pipe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_LOAD;
      ld_r    <= '0;
      j_r     <= '0;
      g_r     <= '0;
      k_r     <= '0;
      pipe_r  <= 2'b00;
    end else begin
      state_r <= state_s;
      ld_r    <= ld_s;
      j_r     <= j_s;
      g_r     <= g_s;
      k_r     <= k_s;
      pipe_r  <= {pipe_r[0], issue_s};
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_s = state_r;
    ld_s    = ld_r;
    j_s     = j_r;
    g_s     = g_r;
    k_s     = k_r;
    issue_s = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (s_valid) begin
          if (ld_r == VW'(N - 1)) begin
            ld_s    = '0;
            state_s = ST_CLEAR;
          end else begin
            ld_s = ld_r + VW'(1);
          end
        end else begin
          ld_s = ld_r;
        end
      end
      ST_CLEAR: begin
        j_s     = '0;
        state_s = ST_MAC;
      end
      ST_MAC: begin
        issue_s = 1'b1;
        if (j_r == VW'(N - 1)) begin
          j_s     = '0;
          state_s = ST_WAIT;
        end else begin
          j_s = j_r + VW'(1);
        end
      end
      ST_WAIT: begin
        // j is reused as the two-cycle flush counter; it is zero on entry.
        if (j_r != '0) begin
          j_s     = '0;
          state_s = ST_DRAIN;
        end else begin
          j_s = VW'(1);
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          if (k_last_s) begin
            k_s = '0;
            if (g_last_s) begin
              g_s     = '0;
              state_s = ST_LOAD;
            end else begin
              g_s     = g_r + GW'(1);
              state_s = ST_CLEAR;
            end
          end else begin
            k_s = k_r + KW'(1);
          end
        end else begin
          k_s = k_r;
        end
      end
      default: begin
        state_s = ST_LOAD;
      end
    endcase
  end

  // Output decode; everything except wr_en_x comes from registered state only.
  always_comb begin
    s_ready   = 1'b0;
    wr_en_x   = 1'b0;
    addr_x    = '0;
    addr_w    = '0;
    clear_acc = 1'b0;
    m_valid   = 1'b0;
    f_sel     = '0;
    m_last    = 1'b0;
    busy      = 1'b1;
    en_acc    = pipe_r[1];
    case (state_r)
      ST_LOAD: begin
        s_ready = 1'b1;
        wr_en_x = s_valid;
        addr_x  = ld_r;
        busy    = 1'b0;
      end
      ST_CLEAR: begin
        clear_acc = 1'b1;
      end
      ST_MAC: begin
        addr_x = j_r;
        addr_w = AW'((int'(g_r) * N) + int'(j_r));
      end
      ST_WAIT: begin
        busy = 1'b1;
      end
      ST_DRAIN: begin
        m_valid = 1'b1;
        f_sel   = P'(k_r);
        m_last  = k_last_s && g_last_s;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

`ifdef MVM_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of stalled output cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == ST_DRAIN) && !m_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_mvm_ctrl_relu.sv
// Directed bench for mvm_ctrl_relu with M=4, N=4, P=2 (two groups of two lanes).
module tb_mvm_ctrl_relu;

  localparam int M = 4;
  localparam int N = 4;
  localparam int P = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic       wr_en_x;
  logic [1:0] addr_x;
  logic [2:0] addr_w;
  logic       clear_acc;
  logic       en_acc;
  logic [1:0] f_sel;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       busy;
`ifdef MVM_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mvm_ctrl_relu #(.M(M), .N(N), .P(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .wr_en_x   (wr_en_x),
    .addr_x    (addr_x),
    .addr_w    (addr_w),
    .clear_acc (clear_acc),
    .en_acc    (en_acc),
    .f_sel     (f_sel),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
`ifdef MVM_CTRL_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .busy      (busy)
  );

  typedef struct {
    logic sv;
    logic mr;
    logic srdy;
    logic wr;
    int   ax;
    int   aw;
    logic clr;
    logic en;
    logic mv;
    int   fs;
    logic last;
    logic bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic sv, input logic mr, input logic srdy, input logic wr,
                     input int ax, input int aw, input logic clr, input logic en,
                     input logic mv, input int fs, input logic last, input logic bsy);
    vec_t v;
    v.sv = sv; v.mr = mr; v.srdy = srdy; v.wr = wr; v.ax = ax; v.aw = aw;
    v.clr = clr; v.en = en; v.mv = mv; v.fs = fs; v.last = last; v.bsy = bsy;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle-accurate expectations for one full vector with m_ready held high.
  task automatic fill_table();
    // LOAD: four accepts at addresses 0..3.
    for (int i = 0; i < 4; i++) add(1, 1, 1, 1, i, 0, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 2; g++) begin
      // CLEAR
      add(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      // MAC: en_acc rises two cycles after addr 0; s_valid in group 1 must be ignored.
      for (int j = 0; j < 4; j++)
        add((g == 1 && j < 2) ? 1'b1 : 1'b0, 1, 0, 0, j, g * 4 + j, 0, (j >= 2) ? 1'b1 : 1'b0, 0, 0, 0, 1);
      // WAIT: last two en_acc pulses.
      add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      // DRAIN lanes 0 and 1; m_last only on the final lane of group 1.
      add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, (g == 1) ? 1'b1 : 1'b0, 1);
    end
    // Back in LOAD right after the m_last handshake.
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      s_valid = tbl[i].sv;
      m_ready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("%s[%0d].s_ready", tag, i),   int'(s_ready),   int'(tbl[i].srdy));
      chk($sformatf("%s[%0d].wr_en_x", tag, i),   int'(wr_en_x),   int'(tbl[i].wr));
      chk($sformatf("%s[%0d].addr_x", tag, i),    int'(addr_x),    tbl[i].ax);
      chk($sformatf("%s[%0d].addr_w", tag, i),    int'(addr_w),    tbl[i].aw);
      chk($sformatf("%s[%0d].clear_acc", tag, i), int'(clear_acc), int'(tbl[i].clr));
      chk($sformatf("%s[%0d].en_acc", tag, i),    int'(en_acc),    int'(tbl[i].en));
      chk($sformatf("%s[%0d].m_valid", tag, i),   int'(m_valid),   int'(tbl[i].mv));
      chk($sformatf("%s[%0d].f_sel", tag, i),     int'(f_sel),     tbl[i].fs);
      chk($sformatf("%s[%0d].m_last", tag, i),    int'(m_last),    int'(tbl[i].last));
      chk($sformatf("%s[%0d].busy", tag, i),      int'(busy),      int'(tbl[i].bsy));
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic load_vec();
    s_valid = 1'b1;
    for (int i = 0; i < N; i++) tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!m_valid && n < max_cycles) begin
      tick();
      n++;
    end
    chk({name, ".timeout"}, int'(m_valid), 1);
  endtask

  initial begin
    int acc;
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    fill_table();
    tick();
    tick();
    // Reset state.
    chk("rst.s_ready", int'(s_ready), 1);
    chk("rst.busy", int'(busy), 0);
    chk("rst.m_valid", int'(m_valid), 0);
    chk("rst.en_acc", int'(en_acc), 0);
    chk("rst.clear_acc", int'(clear_acc), 0);
    chk("rst.addr_x", int'(addr_x), 0);
    chk("rst.addr_w", int'(addr_w), 0);
`ifdef MVM_CTRL_STALL_CNT_EN
    chk("rst.stall_cnt", int'(stall_cnt), 0);
`endif
    reset = 1'b0;

    run_table("run1");

    // Backpressure: five stalled cycles on lane 0 of group 0.
    load_vec();
    m_ready = 1'b0;
    wait_mvalid("bp.g0", 20);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp.hold%0d.m_valid", i), int'(m_valid), 1);
      chk($sformatf("bp.hold%0d.f_sel", i), int'(f_sel), 0);
      chk($sformatf("bp.hold%0d.m_last", i), int'(m_last), 0);
      tick();
    end
`ifdef MVM_CTRL_STALL_CNT_EN
    chk("bp.stall_cnt", int'(stall_cnt), 5);
`endif
    m_ready = 1'b1;
    tick();
    chk("bp.lane1.f_sel", int'(f_sel), 1);
    chk("bp.lane1.m_valid", int'(m_valid), 1);
    tick();
    chk("bp.g1.clear_acc", int'(clear_acc), 1);
    m_ready = 1'b0;
    wait_mvalid("bp.g1", 20);
    chk("bp.g1.lane0.m_last", int'(m_last), 0);
    m_ready = 1'b1;
    tick();
    chk("bp.g1.lane1.m_last", int'(m_last), 1);
    tick();
    m_ready = 1'b0;
    chk("bp.b2b.s_ready", int'(s_ready), 1);
    chk("bp.b2b.busy", int'(busy), 0);
`ifdef MVM_CTRL_STALL_CNT_EN
    chk("bp.stall_cnt_kept", int'(stall_cnt), 5);
`endif

    // Gapped input: only valid cycles write, address advances per accept.
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      s_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      chk($sformatf("gap%0d.wr_en_x", i), int'(wr_en_x), int'(s_valid));
      chk($sformatf("gap%0d.addr_x", i), int'(addr_x), acc);
      if (s_valid) acc++;
      tick();
    end
    s_valid = 1'b0;
    chk("gap.clear_acc", int'(clear_acc), 1);
    chk("gap.busy", int'(busy), 1);
    // s_valid during MAC is ignored.
    s_valid = 1'b1;
    tick();
    chk("mac1.s_ready", int'(s_ready), 0);
    chk("mac1.wr_en_x", int'(wr_en_x), 0);
    chk("mac1.addr_x", int'(addr_x), 0);
    tick();
    s_valid = 1'b0;
    chk("mac2.addr_x", int'(addr_x), 1);
    // Reset in the second MAC cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst.s_ready", int'(s_ready), 1);
    chk("mrst.busy", int'(busy), 0);
    chk("mrst.en_acc", int'(en_acc), 0);
    tick();
    chk("mrst.en_acc_next", int'(en_acc), 0);
    chk("mrst.addr_x", int'(addr_x), 0);

    // Fresh vector after the abandoned one.
    run_table("run2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
